fifo_wr_arbiter: RTL and testbench

- Shares the write port of one sync FIFO between N_REQ producers using round-robin arbitration.
- Tracks FIFO free space with an internal credit counter, so a write is never issued into a full FIFO.
- Checks each issued write against the FIFO's wr_ack/overflow response and raises a sticky error on mismatch.
- Sits between the producer agents and the FIFO write interface; the FIFO read side stays external and is only observed.

---
 rtl/fifo_wr_arbiter_if.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle for fifo_wr_arbiter.
// The arbiter takes the slave modport; the producer/FIFO environment takes master.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            gnt;
    logic                        fifo_wr_en;
    logic [DATA_WIDTH-1:0]       fifo_data_in;
    logic                        fifo_rd_en;
    logic                        fifo_empty;
    logic                        fifo_wr_ack;
    logic                        fifo_overflow;
    logic [CW-1:0]               credits;
    logic                        stall;
    logic                        err;

    modport slave (
        input  req, req_data, fifo_rd_en, fifo_empty, fifo_wr_ack, fifo_overflow,
        output gnt, fifo_wr_en, fifo_data_in, credits, stall, err
    );

    modport master (
        output req, req_data, fifo_rd_en, fifo_empty, fifo_wr_ack, fifo_overflow,
        input  gnt, fifo_wr_en, fifo_data_in, credits, stall, err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for one sync FIFO with credit-based flow control.
// Optional FIFO_ARB_STATS_EN adds per-requester grant counters and a STALL cycle counter.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    fifo_wr_arbiter_if.slave    bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0] grant_cnt,
    output logic [15:0]         stall_cycles
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         credits_reg, credits_next;
    logic [PW-1:0]         rr_ptr_reg, rr_ptr_next;
    logic                  wr_en_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  pend_reg;
    logic                  err_reg;

    logic [DATA_WIDTH-1:0] req_word [N_REQ];
    logic [N_REQ-1:0]      gnt_comb;
    logic [PW-1:0]         gnt_idx;
    logic                  grant_ok;
    logic                  accept;
    logic                  rd;
    logic                  rd_overflow;
    logic                  resp_err;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_word[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign grant_ok = (state_reg != STALL) && (credits_reg != '0);

    // First requester at or after rr_ptr, wrapping; suppressed while reset is held.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt_comb = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        idx      = '0;
        if (!rst && grant_ok) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = PW'((int'(rr_ptr_reg) + k) % N_REQ);
                if (!found && bus.req[idx]) begin
                    found         = 1'b1;
                    gnt_comb[idx] = 1'b1;
                    gnt_idx       = idx;
                end
            end
        end
    end

    assign accept      = |(bus.req & gnt_comb);
    assign rd          = bus.fifo_rd_en & ~bus.fifo_empty;
    assign rd_overflow = rd && !accept && (credits_reg == CW'(FIFO_DEPTH));
    assign resp_err    = pend_reg && (!bus.fifo_wr_ack || bus.fifo_overflow);

    always_comb begin
        credits_next = credits_reg;
        if (accept && !rd)
            credits_next = credits_reg - 1'b1;
        else if (rd && !accept && !rd_overflow)
            credits_next = credits_reg + 1'b1;
    end

    assign rr_ptr_next = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:
                if (|bus.req && credits_reg != '0)
                    state_next = ACTIVE;
            ACTIVE:
                if (credits_next == '0)
                    state_next = STALL;
                else if (!accept && !(|bus.req))
                    state_next = IDLE;
            STALL:
                if (credits_next != '0)
                    state_next = ACTIVE;
            default:
                state_next = IDLE;
        endcase
    end

    // wr_en_reg and pend_reg form the response pipeline: ack is due one cycle after wr_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            credits_reg <= CW'(FIFO_DEPTH);
            rr_ptr_reg  <= '0;
            wr_en_reg   <= 1'b0;
            data_reg    <= '0;
            pend_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            credits_reg <= credits_next;
            wr_en_reg   <= accept;
            pend_reg    <= wr_en_reg;
            err_reg     <= err_reg | resp_err | rd_overflow;
            if (accept) begin
                data_reg   <= req_word[gnt_idx];
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    assign bus.gnt          = gnt_comb;
    assign bus.fifo_wr_en   = wr_en_reg;
    assign bus.fifo_data_in = data_reg;
    assign bus.credits      = credits_reg;
    assign bus.stall        = (state_reg == STALL);
    assign bus.err          = err_reg;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_cnt_reg;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg <= '0;
                else if (accept && gnt_comb[gi] && cnt_reg != 16'hFFFF)
                    cnt_reg <= cnt_reg + 16'd1;
            end
            assign grant_cnt[gi*16 +: 16] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if (state_reg == STALL && stall_cnt_reg != 16'hFFFF)
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end

    assign stall_cycles = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=16, FIFO_DEPTH=8).
// Define FIFO_ARB_STATS_EN to also exercise the statistics counters.
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_nack = 1'b0;
    logic ack_q;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(W), .FIFO_DEPTH(D)) bus_if ();

`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     stall_cycles;
`endif

    fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt),
        .stall_cycles (stall_cycles)
`endif
    );

    // FIFO stand-in: acknowledges each write one cycle later unless force_nack is set.
    always @(posedge clk or posedge rst) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= bus_if.fifo_wr_en & ~force_nack;
    end
    assign bus_if.fifo_wr_ack   = ack_q;
    assign bus_if.fifo_overflow = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_if.req        = '0;
        bus_if.fifo_rd_en = 1'b0;
        bus_if.fifo_empty = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus_if.req = 4'b1111;
        tick();
        checks++; if (bus_if.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL pre_reset_wr_en: got %b expected 1", bus_if.fifo_wr_en); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus_if.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus_if.gnt); end
        checks++; if (bus_if.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus_if.fifo_wr_en); end
        checks++; if (bus_if.credits !== 4'd8) begin errors++; $display("FAIL reset_credits: got %0d expected 8", bus_if.credits); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus_if.credits !== 4'd8) begin errors++; $display("FAIL release_credits: got %0d expected 8", bus_if.credits); end
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL release_err: got %b expected 0", bus_if.err); end
        checks++; if (bus_if.stall !== 1'b0) begin errors++; $display("FAIL release_stall: got %b expected 0", bus_if.stall); end
        checks++; if (bus_if.gnt !== 4'b0001) begin errors++; $display("FAIL release_gnt: got %b expected 0001", bus_if.gnt); end
        bus_if.req = '0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [15:0] exp_d;
        do_reset();
        bus_if.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_g = 4'(1 << i);
            checks++; if (bus_if.gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, bus_if.gnt, exp_g); end
            tick();
            exp_d = 16'hD000 + 16'(i);
            checks++; if (bus_if.fifo_data_in !== exp_d || bus_if.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL rr_data[%0d]: got %h/%b expected %h/1", i, bus_if.fifo_data_in, bus_if.fifo_wr_en, exp_d); end
        end
        bus_if.req = '0;
        checks++; if (bus_if.credits !== 4'd4) begin errors++; $display("FAIL rr_credits: got %0d expected 4", bus_if.credits); end
        tick();
        tick();
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL rr_err: got %b expected 0", bus_if.err); end
        $display("test_round_robin done");
    endtask

    task automatic test_fill_stall();
        int cnt;
        do_reset();
        bus_if.req = 4'b0100;
        cnt = 0;
        repeat (12) begin tick(); if (bus_if.fifo_wr_en) cnt++; end
        checks++; if (cnt != 8) begin errors++; $display("FAIL fill_accepts: got %0d expected 8", cnt); end
        checks++; if (bus_if.credits !== 4'd0) begin errors++; $display("FAIL fill_credits: got %0d expected 0", bus_if.credits); end
        checks++; if (bus_if.stall !== 1'b1) begin errors++; $display("FAIL fill_stall: got %b expected 1", bus_if.stall); end
        checks++; if (bus_if.gnt !== 4'b0000) begin errors++; $display("FAIL fill_gnt: got %b expected 0000", bus_if.gnt); end
        bus_if.fifo_rd_en = 1'b1;
        bus_if.fifo_empty = 1'b0;
        tick();
        bus_if.fifo_rd_en = 1'b0;
        bus_if.fifo_empty = 1'b1;
        checks++; if (bus_if.credits !== 4'd1) begin errors++; $display("FAIL read_credits: got %0d expected 1", bus_if.credits); end
        cnt = 0;
        repeat (6) begin tick(); if (bus_if.fifo_wr_en) cnt++; end
        checks++; if (cnt != 1) begin errors++; $display("FAIL refill_accepts: got %0d expected 1", cnt); end
        checks++; if (bus_if.credits !== 4'd0 || bus_if.stall !== 1'b1) begin errors++; $display("FAIL restall: got credits %0d stall %b expected 0/1", bus_if.credits, bus_if.stall); end
        bus_if.req = '0;
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL fill_err: got %b expected 0", bus_if.err); end
        $display("test_fill_stall done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus_if.req = 4'b0001;
        repeat (5) tick();
        checks++; if (bus_if.credits !== 4'd3) begin errors++; $display("FAIL sim_pre_credits: got %0d expected 3", bus_if.credits); end
        bus_if.fifo_rd_en = 1'b1;
        bus_if.fifo_empty = 1'b0;
        tick();
        bus_if.fifo_rd_en = 1'b0;
        bus_if.fifo_empty = 1'b1;
        bus_if.req = '0;
        checks++; if (bus_if.credits !== 4'd3) begin errors++; $display("FAIL sim_credits: got %0d expected 3", bus_if.credits); end
        checks++; if (bus_if.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL sim_wr_en: got %b expected 1", bus_if.fifo_wr_en); end
        tick();
        checks++; if (bus_if.fifo_wr_en !== 1'b0 || bus_if.credits !== 4'd3) begin errors++; $display("FAIL sim_idle: got wr_en %b credits %0d expected 0/3", bus_if.fifo_wr_en, bus_if.credits); end
        $display("test_simultaneous done");
    endtask

    task automatic test_credit_overflow();
        do_reset();
        bus_if.fifo_rd_en = 1'b1;
        bus_if.fifo_empty = 1'b0;
        tick();
        bus_if.fifo_rd_en = 1'b0;
        bus_if.fifo_empty = 1'b1;
        checks++; if (bus_if.credits !== 4'd8) begin errors++; $display("FAIL ovf_credits: got %0d expected 8", bus_if.credits); end
        checks++; if (bus_if.err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", bus_if.err); end
        $display("test_credit_overflow done");
    endtask

    task automatic test_error();
        do_reset();
        force_nack = 1'b1;
        bus_if.req = 4'b0010;
        tick();
        bus_if.req = '0;
        checks++; if (bus_if.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL err_wr_en: got %b expected 1", bus_if.fifo_wr_en); end
        tick();
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL err_early: got %b expected 0", bus_if.err); end
        tick();
        checks++; if (bus_if.err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus_if.err); end
        force_nack = 1'b0;
        bus_if.req = 4'b0010;
        repeat (4) tick();
        bus_if.req = '0;
        repeat (3) tick();
        checks++; if (bus_if.err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus_if.err); end
        do_reset();
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", bus_if.err); end
        $display("test_error done");
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        bus_if.req = 4'b0010;
        repeat (5) tick();
        bus_if.req = 4'b0001;
        repeat (3) tick();
        bus_if.req = '0;
        checks++; if (bus_if.stall !== 1'b1) begin errors++; $display("FAIL stats_stall_in: got %b expected 1", bus_if.stall); end
        tick();
        tick();
        bus_if.fifo_rd_en = 1'b1;
        bus_if.fifo_empty = 1'b0;
        tick();
        bus_if.fifo_rd_en = 1'b0;
        bus_if.fifo_empty = 1'b1;
        checks++; if (bus_if.stall !== 1'b0) begin errors++; $display("FAIL stats_stall_out: got %b expected 0", bus_if.stall); end
        tick();
        checks++; if (grant_cnt[31:16] !== 16'd5) begin errors++; $display("FAIL stats_gcnt1: got %0d expected 5", grant_cnt[31:16]); end
        checks++; if (grant_cnt[15:0] !== 16'd3) begin errors++; $display("FAIL stats_gcnt0: got %0d expected 3", grant_cnt[15:0]); end
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL stats_stall_cycles: got %0d expected 3", stall_cycles); end
        $display("test_stats done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.req        = '0;
        bus_if.req_data   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        bus_if.fifo_rd_en = 1'b0;
        bus_if.fifo_empty = 1'b1;
        test_reset();
        test_round_robin();
        test_fill_stall();
        test_simultaneous();
        test_credit_overflow();
        test_error();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
